// File: rtl/pattern_seq_pkg.sv
// pattern_seq_pkg: shared types and helpers for the pattern sequencer.
//   seq_state_t : sequencer FSM states (BLANK exists only with BLANK_FRAME_EN)
//   pat_idx_t   : 4-bit pattern index driven to the pattern generator
//   req_t       : pending manual step request
//   PAT_OFF     : index meaning "generator off"
//   idx_next/idx_prev : wrapping steppers over the active range 1..num-1
// Optional feature macro: BLANK_FRAME_EN
package pattern_seq_pkg;

  typedef logic [3:0] pat_idx_t;

  localparam pat_idx_t    PAT_OFF   = 4'd0;
  localparam pat_idx_t    PAT_FIRST = 4'd1;
  localparam int unsigned DWELL_W   = 10;

`ifdef BLANK_FRAME_EN
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SHOW = 2'd1, ST_BLANK = 2'd2} seq_state_t;
`else
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SHOW = 2'd1} seq_state_t;
`endif

  typedef enum logic [1:0] {REQ_NONE = 2'd0, REQ_NEXT = 2'd1, REQ_PREV = 2'd2} req_t;

  // Index 0 is never produced by stepping: the active range is 1..num-1.
  function automatic pat_idx_t idx_next(pat_idx_t cur, int unsigned num);
    if (cur >= pat_idx_t'(num - 1)) return PAT_FIRST;
    return cur + 4'd1;
  endfunction

  function automatic pat_idx_t idx_prev(pat_idx_t cur, int unsigned num);
    if (cur <= PAT_FIRST) return pat_idx_t'(num - 1);
    return cur - 4'd1;
  endfunction

endpackage

// File: rtl/dwell_timer.sv
// dwell_timer: counts frame strobes while enabled; flags the last frame of a dwell.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_clr          : synchronous clear (wins over i_en)
//   i_en           : count one frame this cycle
//   o_count        : frames elapsed in the current dwell
//   o_tc           : count is at DWELL_FRAMES-1 (the next counted frame ends the dwell)
module dwell_timer
  import pattern_seq_pkg::*;
#(
  parameter int unsigned DWELL_FRAMES = 120
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_clr,
  input  logic               i_en,
  output logic [DWELL_W-1:0] o_count,
  output logic               o_tc
);

  logic [DWELL_W-1:0] r_cnt;

  assign o_count = r_cnt;
  assign o_tc    = (r_cnt == DWELL_W'(DWELL_FRAMES - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)  r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_en)  r_cnt <= o_tc ? '0 : r_cnt + 1'b1;
  end

endmodule

// File: rtl/pattern_sequencer.sv
// pattern_sequencer: selects the test-pattern index shown by the pattern generator.
// Changes take effect only at frame boundaries; manual next/prev pulses are held
// as a pending request until the next frame strobe, auto mode advances every
// DWELL_FRAMES frames.
//   i_clk, i_rst_n    : pixel clock, async active-low reset
//   i_enable, i_auto  : generator enable, auto-advance mode (levels)
//   i_next, i_prev    : one-cycle step requests
//   i_frame_strobe    : one-cycle pulse at frame end
//   o_pattern         : pattern index (0 = off)
//   o_switch_strobe   : one-cycle pulse with the first cycle of a new nonzero index
//   o_dwell_count     : frames elapsed in the current auto dwell
// Optional feature macro: BLANK_FRAME_EN (one frame of index 0 between patterns)
module pattern_sequencer
  import pattern_seq_pkg::*;
#(
  parameter int unsigned NUM_PATTERNS = 8,
  parameter int unsigned DWELL_FRAMES = 120
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_enable,
  input  logic               i_auto,
  input  logic               i_next,
  input  logic               i_prev,
  input  logic               i_frame_strobe,
  output logic [3:0]         o_pattern,
  output logic               o_switch_strobe,
  output logic [DWELL_W-1:0] o_dwell_count
);

  seq_state_t r_state, w_state_nx;
  pat_idx_t   r_pat, w_pat_nx;
  pat_idx_t   r_cur, w_cur_nx;   // remembered / target index, survives IDLE
  req_t       r_pend, w_pend_nx;
  logic       r_sw, w_sw_nx;

  req_t       w_pend_eff;
  pat_idx_t   w_tgt;
  logic       w_adv;
  logic       w_dw_clr, w_dw_en, w_dw_tc;

  // A pulse this cycle overrides the held request; both at once changes nothing.
  always_comb begin
    w_pend_eff = r_pend;
    if (i_next && !i_prev)      w_pend_eff = REQ_NEXT;
    else if (i_prev && !i_next) w_pend_eff = REQ_PREV;
  end

  assign w_tgt = (w_pend_eff == REQ_PREV) ? idx_prev(r_cur, NUM_PATTERNS)
                                          : idx_next(r_cur, NUM_PATTERNS);
  // Manual request takes priority over the dwell timeout (both step, manual may be prev).
  assign w_adv = (w_pend_eff != REQ_NONE) || (i_auto && w_dw_tc);

  dwell_timer #(.DWELL_FRAMES(DWELL_FRAMES)) u_dwell (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (w_dw_clr),
    .i_en    (w_dw_en),
    .o_count (o_dwell_count),
    .o_tc    (w_dw_tc)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_pat   <= PAT_OFF;
      r_cur   <= PAT_FIRST;
      r_pend  <= REQ_NONE;
      r_sw    <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_pat   <= w_pat_nx;
      r_cur   <= w_cur_nx;
      r_pend  <= w_pend_nx;
      r_sw    <= w_sw_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_pat_nx   = r_pat;
    w_cur_nx   = r_cur;
    w_pend_nx  = r_pend;
    w_sw_nx    = 1'b0;
    w_dw_clr   = !i_auto;   // manual mode pins the dwell count at 0
    w_dw_en    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_pend_nx = REQ_NONE;   // requests are ignored while off
        w_dw_clr  = 1'b1;
        if (i_frame_strobe && i_enable) begin
          w_state_nx = ST_SHOW;
          w_pat_nx   = r_cur;
          w_sw_nx    = 1'b1;
        end
      end
      ST_SHOW: begin
        w_pend_nx = w_pend_eff;
        if (i_frame_strobe) begin
          w_pend_nx = REQ_NONE;
          if (!i_enable) begin
            w_state_nx = ST_IDLE;
            w_pat_nx   = PAT_OFF;
            w_dw_clr   = 1'b1;
          end else if (w_adv) begin
            w_cur_nx = w_tgt;
            w_dw_clr = 1'b1;
`ifdef BLANK_FRAME_EN
            w_state_nx = ST_BLANK;
            w_pat_nx   = PAT_OFF;
`else
            w_pat_nx = w_tgt;
            w_sw_nx  = (w_tgt != r_pat);
`endif
          end else begin
            w_dw_en = i_auto;
          end
        end
      end
`ifdef BLANK_FRAME_EN
      ST_BLANK: begin
        // Requests here are kept for the change after the new pattern appears.
        w_pend_nx = w_pend_eff;
        w_dw_clr  = 1'b1;
        if (i_frame_strobe) begin
          if (!i_enable) begin
            w_state_nx = ST_IDLE;
            w_pend_nx  = REQ_NONE;
          end else begin
            w_state_nx = ST_SHOW;
            w_pat_nx   = r_cur;
            w_sw_nx    = 1'b1;
          end
        end
      end
`endif
      default: begin
        w_state_nx = ST_IDLE;
        w_pat_nx   = PAT_OFF;
        w_pend_nx  = REQ_NONE;
        w_dw_clr   = 1'b1;
      end
    endcase
  end

  assign o_pattern       = r_pat;
  assign o_switch_strobe = r_sw;

endmodule

// File: tb/tb_pattern_sequencer.sv
module tb_pattern_sequencer;

  localparam int N = 8;
  localparam int D = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, au, nx, pv, fs;
  logic [3:0] pat;
  logic       sw;
  logic [9:0] dw;

  int checks   = 0;
  int failures = 0;

  pattern_sequencer #(.NUM_PATTERNS(N), .DWELL_FRAMES(D)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_enable       (en),
    .i_auto         (au),
    .i_next         (nx),
    .i_prev         (pv),
    .i_frame_strobe (fs),
    .o_pattern      (pat),
    .o_switch_strobe(sw),
    .o_dwell_count  (dw)
  );

  always #5 clk = ~clk;

  // Reference model: mode 0 = off, 1 = showing, 2 = blank frame.
  int m_mode, m_cur, m_pend, m_dw, m_pat, m_sw;

  task automatic model_reset();
    m_mode = 0; m_cur = 1; m_pend = 0; m_dw = 0; m_pat = 0; m_sw = 0;
  endtask

  task automatic model_step(input logic e, a, n, p, f);
    int req, prev, step;
    req  = (n && !p) ? 1 : ((p && !n) ? -1 : 0);
    prev = m_pat;
    m_sw = 0;
    if (m_mode == 0) begin
      if (f && e) begin m_mode = 1; m_pat = m_cur; m_sw = 1; end
    end else begin
      if (req != 0) m_pend = req;
      if (f) begin
        if (!e) begin
          m_mode = 0; m_pat = 0; m_pend = 0; m_dw = 0;
        end else if (m_mode == 2) begin
          m_mode = 1; m_pat = m_cur; m_sw = 1;
        end else begin
          step = 0;
          if (m_pend != 0) begin step = m_pend; m_pend = 0; end
          else if (a) begin
            if (m_dw == D - 1) step = 1;
            else m_dw++;
          end
          if (step != 0) begin
            m_cur = ((m_cur - 1 + step + (N - 1)) % (N - 1)) + 1;
            m_dw  = 0;
`ifdef BLANK_FRAME_EN
            m_mode = 2; m_pat = 0;
`else
            m_pat = m_cur; m_sw = (m_cur != prev) ? 1 : 0;
`endif
          end
        end
      end
    end
    if (!a) m_dw = 0;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".pattern"}, int'(pat), m_pat);
    check({tag, ".switch"},  int'(sw),  m_sw);
    check({tag, ".dwell"},   int'(dw),  m_dw);
  endtask

  task automatic tick(input logic e, a, n, p, f);
    en = e; au = a; nx = n; pv = p; fs = f;
    @(posedge clk);
    model_step(e, a, n, p, f);
    #1;
    check_model("model");
    nx = 1'b0; pv = 1'b0; fs = 1'b0;
  endtask

  // Asynchronous reset pulse placed mid-cycle; outputs must clear at once.
  task automatic pulse_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check({tag, ".rst_pattern"}, int'(pat), 0);
    check({tag, ".rst_switch"},  int'(sw),  0);
    check({tag, ".rst_dwell"},   int'(dw),  0);
    #2 rst_n = 1'b1;
  endtask

  typedef struct {
    logic e, a, n, p, f;
    int   pat, sw, dw;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic e, a, n, p, f, int xp, xs, xd);
    vec_t v;
    v.e = e; v.a = a; v.n = n; v.p = p; v.f = f;
    v.pat = xp; v.sw = xs; v.dw = xd;
    return v;
  endfunction

  initial begin
    rst_n = 1'b0; en = 0; au = 0; nx = 0; pv = 0; fs = 0;
    model_reset();
    #12;
    check("reset.pattern", int'(pat), 0);
    check("reset.switch",  int'(sw),  0);
    check("reset.dwell",   int'(dw),  0);
    rst_n = 1'b1;

    //           en au nx pv fs   pat sw dw
`ifdef BLANK_FRAME_EN
    tbl.push_back(mk(1, 0, 0, 0, 1,  1, 1, 0));
    tbl.push_back(mk(1, 0, 1, 0, 1,  0, 0, 0)); // blank frame
    tbl.push_back(mk(1, 0, 0, 0, 1,  2, 1, 0));
    tbl.push_back(mk(1, 0, 1, 0, 0,  2, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 1,  0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 0,  0, 0, 0)); // latched during blank
    tbl.push_back(mk(1, 0, 0, 0, 1,  3, 1, 0));
    tbl.push_back(mk(1, 0, 0, 0, 1,  0, 0, 0)); // held request applies
    tbl.push_back(mk(1, 0, 0, 0, 1,  4, 1, 0));
    tbl.push_back(mk(1, 0, 1, 1, 1,  4, 0, 0)); // simultaneous ignored
    tbl.push_back(mk(0, 0, 0, 0, 1,  0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 1,  4, 1, 0));
`else
    tbl.push_back(mk(1, 0, 0, 0, 0,  0, 0, 0)); // no strobe, no change
    tbl.push_back(mk(1, 0, 0, 0, 1,  1, 1, 0)); // enable -> 1
    tbl.push_back(mk(1, 0, 0, 0, 0,  1, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 0,  1, 0, 0)); // pending only
    tbl.push_back(mk(1, 0, 0, 0, 1,  2, 1, 0));
    tbl.push_back(mk(1, 0, 1, 1, 0,  2, 0, 0)); // simultaneous
    tbl.push_back(mk(1, 0, 0, 0, 1,  2, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 1,  3, 1, 0)); // coincident with strobe
    tbl.push_back(mk(1, 0, 0, 1, 0,  3, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 0,  3, 0, 0)); // later overwrites
    tbl.push_back(mk(1, 0, 0, 0, 1,  4, 1, 0));
    tbl.push_back(mk(1, 0, 1, 0, 1,  5, 1, 0));
    tbl.push_back(mk(1, 0, 1, 0, 1,  6, 1, 0));
    tbl.push_back(mk(1, 0, 1, 0, 1,  7, 1, 0));
    tbl.push_back(mk(1, 0, 1, 0, 0,  7, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 1,  1, 1, 0)); // wrap up
    tbl.push_back(mk(1, 0, 0, 1, 0,  1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 1,  7, 1, 0)); // wrap down
    tbl.push_back(mk(1, 0, 0, 1, 1,  6, 1, 0));
    tbl.push_back(mk(1, 0, 0, 1, 1,  5, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0,  5, 0, 0)); // disable waits for strobe
    tbl.push_back(mk(0, 0, 0, 0, 1,  0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0,  0, 0, 0)); // ignored while off
    tbl.push_back(mk(1, 0, 0, 0, 0,  0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 1,  5, 1, 0)); // remembered index
    tbl.push_back(mk(1, 0, 0, 0, 1,  5, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 1,  5, 0, 1)); // auto dwell
    tbl.push_back(mk(1, 1, 0, 0, 0,  5, 0, 1));
    tbl.push_back(mk(1, 1, 0, 0, 1,  5, 0, 2));
    tbl.push_back(mk(1, 1, 0, 0, 1,  6, 1, 0)); // third strobe advances
    tbl.push_back(mk(1, 1, 0, 0, 1,  6, 0, 1));
    tbl.push_back(mk(1, 1, 1, 0, 0,  6, 0, 1));
    tbl.push_back(mk(1, 1, 0, 0, 1,  7, 1, 0)); // manual in auto clears dwell
    tbl.push_back(mk(1, 1, 0, 0, 1,  7, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0,  7, 0, 0)); // manual holds 0
`endif

    foreach (tbl[i]) begin
      tick(tbl[i].e, tbl[i].a, tbl[i].n, tbl[i].p, tbl[i].f);
      check($sformatf("vec%0d.pattern", i), int'(pat), tbl[i].pat);
      check($sformatf("vec%0d.switch", i),  int'(sw),  tbl[i].sw);
      check($sformatf("vec%0d.dwell", i),   int'(dw),  tbl[i].dw);
    end

    // Reset mid-dwell: progress discarded, nothing moves until a strobe.
    tick(1, 1, 0, 0, 1);
    tick(1, 1, 0, 0, 1);
    pulse_reset("middwell");
    tick(1, 1, 1, 0, 0);
    check("postrst.hold", int'(pat), 0);
    tick(1, 1, 0, 0, 1);
    check("postrst.first", int'(pat), 1);
    check("postrst.strobe", int'(sw), 1);

    // Randomized traffic against the model.
    begin
      logic r_en, r_au;
      r_en = 1'b1; r_au = 1'b0;
      for (int c = 0; c < 3000; c++) begin
        if ($urandom_range(15) == 0) r_en = ~r_en;
        if ($urandom_range(40) == 0) r_au = ~r_au;
        tick(r_en, r_au, ($urandom_range(7) == 0), ($urandom_range(7) == 0),
             ($urandom_range(3) == 0));
        if ($urandom_range(300) == 0) pulse_reset("rand");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
